// File: rtl/pipeline_control_unit.sv
// Pipeline control unit for a 5-stage in-order core.
// Generates the same-cycle PC / IF/ID / ID/EX control strobes from the pending hazard
// requests, retires the pipeline after an exit ecall, and keeps performance counters.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high reset
//   is_stall       load-use / ecall operand stall request for the instruction in ID
//   mispredict_ex  branch/jump resolved in EX with the wrong next PC
//   is_halt_id     exit ecall (x17 == 10) sitting in ID
//   pc_write       PC register write enable
//   if_id_write    IF/ID register write enable
//   if_id_flush    IF/ID loads a NOP
//   id_ex_bubble   ID/EX loads a NOP
//   is_halted      registered, high only once the pipeline has drained after a halt
//   cycle_count    cycles spent running or draining
//   stall_count    cycles lost to ID stalls
//   flush_count    mispredict flushes
module pipeline_control_unit #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic        mispredict_ex,
  input  logic        is_halt_id,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        is_halted,
  output logic [31:0] cycle_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic [31:0]     cycle_q, stall_q, flush_q;
  logic            stall_hit, flush_hit;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    stall_hit    = 1'b0;
    flush_hit    = 1'b0;

    // While reset is held the state register may still hold DRAIN/HALTED, but the
    // strobes must already behave as in RUN.
    if (reset || state_q == StRun) begin
      if (mispredict_ex) begin
        // The instruction in ID is wrong-path, so its stall/halt requests are moot.
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        flush_hit    = !reset;
      end else if (is_stall) begin
        id_ex_bubble = 1'b1;
        stall_hit    = !reset;
      end else if (is_halt_id) begin
        // Freeze fetch, let the ecall move on into EX and start draining.
        id_ex_bubble = 1'b0;
        state_d      = StDrain;
        drain_d      = CntW'(DRAIN_CYCLES - 1);
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
      end
    end else begin
      unique case (state_q)
        StDrain: begin
          if (drain_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_d = drain_q - CntW'(1);
          end
        end
        StHalted: state_d = StHalted;
        default:  state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      drain_q <= '0;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (state_q != StHalted) cycle_q <= cycle_q + 32'd1;
      if (stall_hit)           stall_q <= stall_q + 32'd1;
      if (flush_hit)           flush_q <= flush_q + 32'd1;
    end
  end

  assign is_halted   = (state_q == StHalted);
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: a vector table, directed corner
// sequences and a randomized run, all compared against a cycle-index reference model.
module tb_pipeline_control_unit;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        is_stall = 1'b0;
  logic        mispredict_ex = 1'b0;
  logic        is_halt_id = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
  logic [31:0] cycle_count, stall_count, flush_count;

  pipeline_control_unit #(.DRAIN_CYCLES(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .is_stall      (is_stall),
    .mispredict_ex (mispredict_ex),
    .is_halt_id    (is_halt_id),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .is_halted     (is_halted),
    .cycle_count   (cycle_count),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles are indexed since reset; a halt accepted in cycle a means
  // cycles a+1..a+D drain and everything afterwards is halted.
  logic [31:0] m_cycle, m_stall, m_flush;
  int          cyc_idx   = 0;
  int          accept_at = -1;

  typedef struct {
    logic       m;
    logic       s;
    logic       h;
    logic [3:0] ctrl;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  } vec_t;

  vec_t tbl[7];

  function automatic int phase();
    if (accept_at < 0) return 0;
    if (cyc_idx - accept_at <= D) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] exp_ctrl(int ph, logic m, logic s, logic h);
    if (ph != 0) return 4'b0001;
    if (m)       return 4'b1111;
    if (s)       return 4'b0001;
    if (h)       return 4'b0000;
    return 4'b1100;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic m, logic s, logic h);
    mispredict_ex = m;
    is_stall      = s;
    is_halt_id    = h;
    #1;
  endtask

  task automatic check_model();
    int ph = phase();
    chk("ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble},
        {28'd0, exp_ctrl(ph, mispredict_ex, is_stall, is_halt_id)});
    chk("is_halted", {31'd0, is_halted}, {31'd0, ph == 2});
    chk("cycle_count", cycle_count, m_cycle);
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
  endtask

  task automatic advance();
    int ph;
    @(posedge clk);
    ph = phase();
    if (ph != 2) m_cycle = m_cycle + 32'd1;
    if (ph == 0) begin
      if (mispredict_ex)   m_flush = m_flush + 32'd1;
      else if (is_stall)   m_stall = m_stall + 32'd1;
      else if (is_halt_id) accept_at = cyc_idx;
    end
    cyc_idx++;
    @(negedge clk);
  endtask

  task automatic step(logic m, logic s, logic h);
    drive(m, s, h);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    logic m, s, h;
    reset = 1'b1;
    m = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    h = 1'($urandom_range(0, 1));
    drive(m, s, h);
    chk("ctrl_in_reset", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble},
        {28'd0, exp_ctrl(0, m, s, h)});
    @(posedge clk);
    m_cycle = '0; m_stall = '0; m_flush = '0;
    cyc_idx = 0; accept_at = -1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk("halted_after_reset", {31'd0, is_halted}, 32'd0);
    chk("cycle_after_reset", cycle_count, 32'd0);
    chk("stall_after_reset", stall_count, 32'd0);
    chk("flush_after_reset", flush_count, 32'd0);
  endtask

  initial begin
    tbl[0] = '{m: 1'b0, s: 1'b0, h: 1'b0, ctrl: 4'b1100};
    tbl[1] = '{m: 1'b1, s: 1'b0, h: 1'b0, ctrl: 4'b1111};
    tbl[2] = '{m: 1'b1, s: 1'b1, h: 1'b0, ctrl: 4'b1111};
    tbl[3] = '{m: 1'b1, s: 1'b0, h: 1'b1, ctrl: 4'b1111};
    tbl[4] = '{m: 1'b1, s: 1'b1, h: 1'b1, ctrl: 4'b1111};
    tbl[5] = '{m: 1'b0, s: 1'b1, h: 1'b0, ctrl: 4'b0001};
    tbl[6] = '{m: 1'b0, s: 1'b1, h: 1'b1, ctrl: 4'b0001};
    m_cycle = '0; m_stall = '0; m_flush = '0;

    @(negedge clk);
    do_reset();

    // Idle run.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk("idle_cycles", cycle_count, 32'd10);
    chk("idle_stalls", stall_count, 32'd0);
    chk("idle_flushes", flush_count, 32'd0);

    // Vector table in RUN, none of these leaves RUN.
    foreach (tbl[i]) begin
      drive(tbl[i].m, tbl[i].s, tbl[i].h);
      chk($sformatf("tbl%0d_ctrl", i),
          {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, {28'd0, tbl[i].ctrl});
      check_model();
      advance();
    end
    chk("tbl_cycles", cycle_count, 32'd17);
    chk("tbl_stalls", stall_count, 32'd2);
    chk("tbl_flushes", flush_count, 32'd4);

    // Two-cycle stall, then mispredict overriding stall and halt.
    do_reset();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("stall2_count", stall_count, 32'd2);
    step(1'b1, 1'b1, 1'b1);
    chk("mp_flush", flush_count, 32'd1);
    chk("mp_stall", stall_count, 32'd2);
    step(1'b0, 1'b0, 1'b0);
    chk("mp_still_run_halted", {31'd0, is_halted}, 32'd0);

    // Halt masked by stall, accepted once stall drops, then drain and halt.
    do_reset();
    drive(1'b0, 1'b1, 1'b1);
    chk("halt_stall_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'h1);
    check_model();
    advance();
    drive(1'b0, 1'b0, 1'b1);
    chk("halt_accept_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'h0);
    check_model();
    advance();
    for (int i = 0; i < D; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("drain_ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble}, 32'h1);
      chk("drain_not_halted", {31'd0, is_halted}, 32'd0);
      check_model();
      advance();
    end
    chk("halted_after_drain", {31'd0, is_halted}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk("halted_cycle_frozen", cycle_count, 32'd5);
    chk("halted_flush_frozen", flush_count, 32'd0);

    // Reset out of HALTED, then cycle_count wrap via backdoor.
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    dut.cycle_q = 32'hFFFF_FFFF;
    m_cycle = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0);
    chk("cycle_wrap", cycle_count, 32'd0);

    // Reset in the middle of DRAIN.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    chk("post_mid_drain_run", {31'd0, pc_write}, 32'd1);

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, number of cycles from halt acceptance until the halting ecall has left WB.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port is_stall  input  1  load-use/ecall operand stall request for the instruction in ID.
REQ-005 SHALL have port mispredict_ex  input  1  branch/jump resolved in EX with wrong next-PC.
REQ-006 SHALL have port is_halt_id  input  1  ecall in ID with x17 == 10.
REQ-007 SHALL have port pc_write  output  1  PC register write enable.
REQ-008 SHALL have port if_id_write  output  1  IF/ID register write enable.
REQ-009 SHALL have port if_id_flush  output  1  IF/ID loads a NOP.
REQ-010 SHALL have port id_ex_bubble  output  1  ID/EX loads a NOP (control bits zeroed).
REQ-011 SHALL have port is_halted  output  1  registered; high only in state HALTED.
REQ-012 SHALL have ports cycle_count, stall_count, flush_count  output  32 each  performance counters.

Function
REQ-013 SHALL implement FSM states RUN, DRAIN, HALTED plus a drain down-counter of width clog2(DRAIN_CYCLES)+1.
REQ-014 SHALL derive pc_write, if_id_write, if_id_flush, id_ex_bubble combinationally from current state and inputs (same-cycle effect).
REQ-015 RUN, mispredict_ex=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; is_stall and is_halt_id ignored (the ID instruction is wrong-path).
REQ-016 RUN, mispredict_ex=0, is_stall=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1; is_halt_id ignored this cycle.
REQ-017 RUN, mispredict_ex=0, is_stall=0, is_halt_id=1: pc_write=0, if_id_write=0, id_ex_bubble=0 (ecall advances to EX); next state DRAIN, drain counter loaded with DRAIN_CYCLES-1.
REQ-018 RUN, no request: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-019 DRAIN: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1; all inputs ignored; counter decrements each cycle; when counter==0, next state HALTED (exactly DRAIN_CYCLES cycles in DRAIN).
REQ-020 HALTED: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1; state held until reset.
REQ-021 cycle_count SHALL increment by 1 every cycle in RUN or DRAIN, frozen in HALTED.
REQ-022 stall_count SHALL increment on cycles matching REQ-016 only.
REQ-023 flush_count SHALL increment on cycles matching REQ-015 only.
REQ-024 Counters SHALL wrap modulo 2^32 (0xFFFFFFFF -> 0), no saturation, no overflow flag.

Reset
REQ-025 reset=1 at a rising edge SHALL set state RUN, drain counter 0, is_halted=0, all counters 0, from any state including mid-DRAIN or HALTED.
REQ-026 While reset is high, combinational outputs SHALL follow RUN rules; counters SHALL not increment.
REQ-027 First cycle after reset deasserts SHALL count as cycle_count=1 at its closing edge.

Verification
REQ-028 Reset then 10 idle cycles -> pc_write=1, if_id_write=1 throughout; cycle_count=10, stall_count=0, flush_count=0.
REQ-029 is_stall=1 for 2 cycles -> pc_write=0, if_id_write=0, id_ex_bubble=1 both cycles; stall_count=2.
REQ-030 mispredict_ex=1 with is_stall=1 and is_halt_id=1 same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1, stall_count=0, state stays RUN.
REQ-031 is_halt_id=1 alone -> DRAIN for exactly 3 cycles (pc_write=0, bubble=1), is_halted=1 on 4th cycle after acceptance; cycle_count frozen thereafter.
REQ-032 is_halt_id=1 with is_stall=1 -> no transition; drop is_stall next cycle -> halt accepted then.
REQ-033 Force cycle_count to 0xFFFFFFFF (via run length or backdoor), one RUN cycle -> 0; reset asserted mid-DRAIN -> state RUN, is_halted=0, all counters 0.
